// File: rtl/disp_scheduler.sv
// disp_scheduler: arbitrates the shared 4-digit 7-seg path between the live
// score, a timed point-event banner and a flashing game-over banner.
// All outputs are registered from the next-state values, so a state change
// or input change shows up on the outputs one clk later.
// Optional feature macro: DISP_SCHEDULER_LEAD_ZERO_BLANK_EN
//   defined   -> in SCORE, blank the tens digit of each player when it is 0
//   undefined -> leading zeros are shown
module disp_scheduler #(
  parameter int EVT_MS   = 1000,
  parameter int FLASH_MS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1k,
  input  logic [15:0] score_data,
  input  logic        evt_req,
  input  logic        evt_who,
  input  logic        over_req,
  input  logic        over_winner,
  output logic [15:0] disp_data,
  output logic [3:0]  blank,
  output logic [1:0]  src,
  output logic        busy,
  output logic        evt_ack
);

  localparam int MAX_MS = (EVT_MS > FLASH_MS) ? EVT_MS : FLASH_MS;
  localparam int CW     = $clog2(MAX_MS + 1);
  localparam logic [CW-1:0] EVT_LOAD   = CW'(EVT_MS - 1);
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_MS - 1);

  // Encoding doubles as the src output code.
  typedef enum logic [1:0] {
    ST_SCORE = 2'b00,
    ST_EVENT = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // hold counter in EVENT, flash counter in OVER
  logic          who_q, who_d;      // player latched with the accepted event
  logic          dark_q, dark_d;    // OVER flash phase: 1 = digits off
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    blank_q, blank_d;
  logic [1:0]    src_q, src_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;

  // Next-state logic: over_req has priority over evt_req everywhere, and a
  // retrigger has priority over the final tick of an event banner.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    who_d   = who_q;
    dark_d  = dark_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_SCORE: begin
        if (over_req) begin
          state_d = ST_OVER;
          cnt_d   = FLASH_LOAD;
          dark_d  = 1'b0;
        end else if (evt_req) begin
          state_d = ST_EVENT;
          who_d   = evt_who;
          cnt_d   = EVT_LOAD;
          ack_d   = 1'b1;
        end
      end
      ST_EVENT: begin
        if (over_req) begin
          state_d = ST_OVER;
          cnt_d   = FLASH_LOAD;
          dark_d  = 1'b0;
        end else if (evt_req) begin
          who_d   = evt_who;
          cnt_d   = EVT_LOAD;
          ack_d   = 1'b1;
        end else if (tick_1k) begin
          if (cnt_q == '0) begin
            state_d = ST_SCORE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_OVER: begin
        if (!over_req) begin
          state_d = ST_SCORE;
          cnt_d   = '0;
          dark_d  = 1'b0;
        end else if (tick_1k) begin
          if (cnt_q == '0) begin
            dark_d = ~dark_q;
            cnt_d  = FLASH_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_SCORE;
        cnt_d   = '0;
        dark_d  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state, so outputs register alongside it.
  always_comb begin
    disp_d  = score_data;
    blank_d = 4'b0000;
    src_d   = state_d;
    busy_d  = (state_d != ST_SCORE);
    case (state_d)
      ST_EVENT: disp_d = {4'hA, (who_d ? 4'h2 : 4'h1), 8'hBB};
      ST_OVER: begin
        disp_d  = {4'hA, (over_winner ? 4'h2 : 4'h1), 8'hBB};
        blank_d = {4{dark_d}};
      end
      default: begin
        disp_d = score_data;
`ifdef DISP_SCHEDULER_LEAD_ZERO_BLANK_EN
        blank_d = {(score_data[15:12] == 4'h0), 1'b0,
                   (score_data[7:4] == 4'h0), 1'b0};
`else
        blank_d = 4'b0000;
`endif
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_SCORE;
      cnt_q   <= '0;
      who_q   <= 1'b0;
      dark_q  <= 1'b0;
      disp_q  <= 16'h0000;
      blank_q <= 4'b1111;
      src_q   <= 2'b00;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      who_q   <= who_d;
      dark_q  <= dark_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign disp_data = disp_q;
  assign blank     = blank_q;
  assign src       = src_q;
  assign busy      = busy_q;
  assign evt_ack   = ack_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Testbench for disp_scheduler with EVT_MS=3, FLASH_MS=2.
// Directed vector table, hand sequences for flash and mid-banner reset,
// then randomized stimulus checked against a behavioural model.
module tb_disp_scheduler;

  localparam int EVT_MS   = 3;
  localparam int FLASH_MS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1k = 1'b0;
  logic [15:0] score_data = 16'h0000;
  logic        evt_req = 1'b0;
  logic        evt_who = 1'b0;
  logic        over_req = 1'b0;
  logic        over_winner = 1'b0;
  logic [15:0] disp_data;
  logic [3:0]  blank;
  logic [1:0]  src;
  logic        busy;
  logic        evt_ack;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  disp_scheduler #(.EVT_MS(EVT_MS), .FLASH_MS(FLASH_MS)) dut (
    .clk(clk), .rst(rst), .tick_1k(tick_1k), .score_data(score_data),
    .evt_req(evt_req), .evt_who(evt_who), .over_req(over_req),
    .over_winner(over_winner), .disp_data(disp_data), .blank(blank),
    .src(src), .busy(busy), .evt_ack(evt_ack)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected SCORE-state blank mask for a given score word.
  function automatic logic [3:0] lz(input logic [15:0] s);
`ifdef DISP_SCHEDULER_LEAD_ZERO_BLANK_EN
    return {(s[15:12] == 4'h0), 1'b0, (s[7:4] == 4'h0), 1'b0};
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_disp, input logic [3:0] e_blank,
                         input logic [1:0] e_src, input logic e_ack);
    chk({tag, ".disp"},  disp_data, e_disp);
    chk({tag, ".blank"}, 16'(blank), 16'(e_blank));
    chk({tag, ".src"},   16'(src), 16'(e_src));
    chk({tag, ".busy"},  16'(busy), 16'(e_src != 2'b00));
    chk({tag, ".ack"},   16'(evt_ack), 16'(e_ack));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, tick, evt, who, over, win;
    logic [15:0] score;
    logic [15:0] e_disp;
    logic [3:0]  e_blank;
    logic [1:0]  e_src;
    logic        e_ack;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic t, input logic e, input logic w, input logic o,
                     input logic wn, input logic [15:0] s, input logic [15:0] ed,
                     input logic [3:0] eb, input logic [1:0] es, input logic ea);
    vec_t v;
    v.rst = r; v.tick = t; v.evt = e; v.who = w; v.over = o; v.win = wn; v.score = s;
    v.e_disp = ed; v.e_blank = eb; v.e_src = es; v.e_ack = ea;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_mode;     // 0 score, 1 event, 2 over
  int          m_left;     // ticks remaining before the event banner ends
  int          m_fticks;   // ticks seen since entering OVER
  logic        m_who;
  logic [15:0] m_disp;
  logic [3:0]  m_blank;
  logic        m_ack;

  task automatic model_step();
    if (!rst) begin
      m_mode = 0; m_left = 0; m_fticks = 0; m_who = 1'b0;
      m_disp = 16'h0000; m_blank = 4'hF; m_ack = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (m_mode == 0) begin
        if (over_req) begin m_mode = 2; m_fticks = 0; end
        else if (evt_req) begin m_mode = 1; m_who = evt_who; m_left = EVT_MS; m_ack = 1'b1; end
      end else if (m_mode == 1) begin
        if (over_req) begin m_mode = 2; m_fticks = 0; end
        else if (evt_req) begin m_who = evt_who; m_left = EVT_MS; m_ack = 1'b1; end
        else if (tick_1k) begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end else begin
        if (!over_req) m_mode = 0;
        else if (tick_1k) m_fticks++;
      end
      if (m_mode == 0) begin
        m_disp = score_data; m_blank = lz(score_data);
      end else if (m_mode == 1) begin
        m_disp = {4'hA, (m_who ? 4'h2 : 4'h1), 8'hBB}; m_blank = 4'h0;
      end else begin
        m_disp = {4'hA, (over_winner ? 4'h2 : 4'h1), 8'hBB};
        m_blank = (((m_fticks / FLASH_MS) % 2) == 1) ? 4'hF : 4'h0;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: reset, event timing, retrigger, abort, priority, flash.
    for (int i = 0; i < 3; i++)
      add(0,0,1,1,0,0, 16'h0312, 16'h0000, 4'hF, 2'b00, 0);
    add(1,0,0,0,0,0, 16'h0312, 16'h0312, lz(16'h0312), 2'b00, 0);
    add(1,0,1,1,0,0, 16'h0312, 16'hA2BB, 4'h0, 2'b01, 1);
    add(1,0,0,0,0,0, 16'h0312, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0312, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0312, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0312, 16'h0312, lz(16'h0312), 2'b00, 0);
    add(1,0,0,0,0,0, 16'h0709, 16'h0709, lz(16'h0709), 2'b00, 0);
    add(1,0,1,1,0,0, 16'h0709, 16'hA2BB, 4'h0, 2'b01, 1);
    add(1,1,0,0,0,0, 16'h0709, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0709, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,0,1,0,0,0, 16'h0709, 16'hA1BB, 4'h0, 2'b01, 1);
    add(1,1,0,0,0,0, 16'h0709, 16'hA1BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0709, 16'hA1BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0709, 16'h0709, lz(16'h0709), 2'b00, 0);
    add(1,1,1,1,0,0, 16'h0709, 16'hA2BB, 4'h0, 2'b01, 1);
    add(1,1,0,0,0,0, 16'h0709, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,1,0,0,0,0, 16'h0709, 16'hA2BB, 4'h0, 2'b01, 0);
    add(1,1,1,0,0,0, 16'h0709, 16'hA1BB, 4'h0, 2'b01, 1);
    add(1,0,0,0,1,0, 16'h0709, 16'hA1BB, 4'h0, 2'b10, 0);
    add(1,0,0,0,0,0, 16'h0709, 16'h0709, lz(16'h0709), 2'b00, 0);
    add(1,0,1,0,1,1, 16'h0709, 16'hA2BB, 4'h0, 2'b10, 0);
    add(1,1,0,0,1,1, 16'h0709, 16'hA2BB, 4'h0, 2'b10, 0);
    add(1,1,0,0,1,1, 16'h0709, 16'hA2BB, 4'hF, 2'b10, 0);
    add(1,1,0,0,1,1, 16'h0709, 16'hA2BB, 4'hF, 2'b10, 0);
    add(1,1,0,0,1,1, 16'h0709, 16'hA2BB, 4'h0, 2'b10, 0);
    add(1,0,1,1,1,1, 16'h0709, 16'hA2BB, 4'h0, 2'b10, 0);
    add(1,0,0,0,0,1, 16'h0709, 16'h0709, lz(16'h0709), 2'b00, 0);

    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; tick_1k = tbl[i].tick; evt_req = tbl[i].evt; evt_who = tbl[i].who;
      over_req = tbl[i].over; over_winner = tbl[i].win; score_data = tbl[i].score;
      clk_step();
      $display("vec %0d: disp=%h blank=%b src=%b ack=%b", i, disp_data, blank, src, evt_ack);
      chk_all($sformatf("vec%0d", i), tbl[i].e_disp, tbl[i].e_blank, tbl[i].e_src, tbl[i].e_ack);
    end
    tick_1k = 0; evt_req = 0;

    // Hand sequence: 8 ticks of OVER flash, ticks separated by idle cycles.
    over_req = 1; over_winner = 0; score_data = 16'h0709;
    clk_step();
    chk_all("flash.entry", 16'hA1BB, 4'h0, 2'b10, 0);
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] eb;
      eb = (((k / FLASH_MS) % 2) == 1) ? 4'hF : 4'h0;
      tick_1k = 1; clk_step();
      tick_1k = 0;
      $display("flash tick %0d: blank=%b", k, blank);
      chk_all($sformatf("flash.t%0d", k), 16'hA1BB, eb, 2'b10, 0);
      clk_step();
      chk($sformatf("flash.hold%0d", k), 16'(blank), 16'(eb));
    end
    over_req = 0; clk_step();
    $display("flash exit: disp=%h blank=%b src=%b", disp_data, blank, src);
    chk_all("flash.exit", 16'h0709, lz(16'h0709), 2'b00, 0);

    // Hand sequence: reset in the middle of an event banner, evt_req held.
    evt_req = 1; evt_who = 1; clk_step();
    chk_all("midrst.evt", 16'hA2BB, 4'h0, 2'b01, 1);
    rst = 0; clk_step();
    $display("mid-banner reset: disp=%h blank=%b src=%b", disp_data, blank, src);
    chk_all("midrst.rst", 16'h0000, 4'hF, 2'b00, 0);
    evt_req = 0; rst = 1; clk_step();
    chk_all("midrst.rel", 16'h0709, lz(16'h0709), 2'b00, 0);

    // Randomized phase against the behavioural model.
    rst = 0;
    model_step();
    clk_step();
    chk_all("rnd.init", m_disp, m_blank, 2'(m_mode), m_ack);
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) >= 2);
      tick_1k     = ($urandom_range(0, 99) < 25);
      evt_req     = ($urandom_range(0, 99) < 10);
      evt_who     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 4) over_req = ~over_req;
      over_winner = 1'($urandom_range(0, 1));
      score_data  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      model_step();
      clk_step();
      chk_all($sformatf("rnd%0d", n), m_disp, m_blank, 2'(m_mode), m_ack);
    end
    $display("random phase: 3000 cycles compared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
Name: disp_scheduler

Overview:
- Owns the shared 4-digit 7-seg display path and decides which source drives it: live score (default), a timed point-event banner, or a flashing game-over banner.
- Sits between the score merger (BCD score word) and the digit encoder / hc595 chain.
- Outputs a registered 16-bit digit-code word plus a per-digit blank mask.

Parameters:
- EVT_MS, 1000, event-banner hold time in tick_1k periods; legal range >= 1.
- FLASH_MS, 250, game-over half-period in tick_1k periods; legal range >= 1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-low
- tick_1k  input  1  one-clk-wide enable pulse at 1 kHz
- score_data  input  16  BCD score digits {P1 tens, P1 ones, P2 tens, P2 ones}
- evt_req  input  1  one-cycle pulse: a point was scored
- evt_who  input  1  player credited with the point; 0 = P1, 1 = P2; sampled with evt_req
- over_req  input  1  level: game is over
- over_winner  input  1  0 = P1, 1 = P2; sampled every cycle while in OVER
- disp_data  output  16  digit codes, [15:12] leftmost
- blank  output  4  1 = digit off; bit 3 is leftmost
- src  output  2  active source: 00 SCORE, 01 EVENT, 10 OVER
- busy  output  1  1 while in EVENT or OVER
- evt_ack  output  1  one-cycle pulse when evt_req is accepted

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-low.
- Reset values: state SCORE, disp_data 16'h0000, blank 4'b1111, src 00, busy 0, evt_ack 0, all counters 0.
- Digit codes: 0-9 are decimal digits; 4'hA = 'P', 4'hB = '-'; 4'hC-4'hF are unused.
- All outputs are registered. Any state change or input change appears on the outputs exactly 1 clk later.
- State SCORE:
  - disp_data = score_data; blank = 0000; src = 00.
  - over_req=1 -> OVER.
  - Otherwise, evt_req=1 -> EVENT: latch evt_who, load hold counter with EVT_MS-1, pulse evt_ack.
- State EVENT:
  - disp_data = {A, 1 or 2, B, B}, i.e. "P1--" or "P2--"; blank = 0000; src = 01.
  - On each tick_1k: if counter = 0 -> SCORE, else decrement the counter.
  - evt_req during EVENT retriggers: re-latch evt_who, reload EVT_MS-1, pulse evt_ack, stay in EVENT.
  - over_req=1 aborts to OVER next cycle, regardless of counter value.
- State OVER:
  - disp_data = {A, 1 or 2, B, B} from the current over_winner; src = 10.
  - On entry: blank = 0000 (lit phase); flash counter loaded with FLASH_MS-1.
  - On each tick_1k: if counter = 0, invert all blank bits and reload; else decrement.
  - over_req=0 -> SCORE next cycle.
  - evt_req is ignored in OVER: no ack and not queued.
- Simultaneous events:
  - evt_req and over_req in the same cycle in SCORE: OVER wins, no evt_ack.
  - evt_req and the final tick in EVENT in the same cycle: retrigger wins, state stays EVENT.
- busy = (src != 00), registered with src.
- Counter widths: $clog2(max(EVT_MS, FLASH_MS)+1). No wrap-around is reachable, because reload always precedes underflow.
- Reset mid-banner: rst=0 in any state returns all outputs to reset values on the next clk edge. evt_req is ignored while rst=0.
- tick_1k high for more than one clk is treated as one tick per clk (no edge detect). Callers must supply a single-cycle pulse.

Optional Feature:
- Macro: DISP_SCHEDULER_LEAD_ZERO_BLANK_EN.
- Defined: in SCORE state only, blank[3] = 1 when score_data[15:12] = 0, and blank[1] = 1 when score_data[7:4] = 0. EVENT and OVER are unaffected.
- Undefined: blank = 0000 in SCORE, so leading zeros are shown.

Test Plan:
- Reset: hold rst=0 for 3 clk with evt_req=1 -> disp_data=0000, blank=1111, src=00, evt_ack never 1. After release with score_data=16'h0312 -> disp_data=0312, blank=0000 one clk later.
- Event timing: EVT_MS=3, pulse evt_req with evt_who=1 -> evt_ack 1 clk; disp_data=A2BB, src=01, busy=1. After the 3rd tick_1k, next clk -> disp_data=score_data, src=00.
- Retrigger: EVT_MS=3, second evt_req (evt_who=0) after 2 ticks -> evt_ack again; disp_data=A1BB; 3 more ticks required before returning to SCORE.
- Abort and priority: over_req=1 mid-EVENT -> src=10 next clk. In SCORE, assert evt_req and over_req together -> src=10, evt_ack=0.
- Flash: FLASH_MS=2, over_winner=0, over_req held for 8 ticks -> disp_data=A1BB; blank toggles 0000/1111 every 2 ticks, starting lit. Drop over_req -> src=00, blank=0000 next clk.
- Lead-zero blanking (macro defined): score_data=16'h0709 -> blank=1010. Same stimulus with the macro undefined -> blank=0000.
